key_conditioner: RTL
====================

Name: key_conditioner

Overview:
- Front end for the four board push-buttons, sitting directly upstream of the 25 MHz video stage and clocked by the same divided clock.
- Synchronises the raw asynchronous key pins and debounces them per key.
- Delivers a clean pressed-level vector plus one-cycle press, release and auto-repeat pulses.
- The video stage consumes the level vector; the pulse outputs serve menu and cursor logic.

Parameters:
- ACTIVE_LOW, 1, raw pin level meaning "pressed" is 0 when 1, is 1 when 0.
- DEBOUNCE_CYC, 250000, consecutive stable cycles required to accept a change (10 ms at 25 MHz); minimum 2.
- REPEAT_DELAY, 12500000, held cycles after the accepted press before the first repeat pulse (500 ms).
- REPEAT_RATE, 2500000, cycles between subsequent repeat pulses (100 ms); minimum 1.
- CNT_W, 24, width of all internal counters; must hold the largest of the three cycle parameters.

Ports:
- clock, input, 1, 25 MHz system clock.
- reset, input, 1, synchronous, active-high.
- key_in, input, 4, raw asynchronous key pins.
- key, output, 4, debounced level, 1 = pressed.
- press, output, 4, one-cycle pulse when a key becomes pressed.
- release, output, 4, one-cycle pulse when a key becomes released.
- repeat, output, 4, one-cycle pulse per auto-repeat tick while a key is held.
- any_key, output, 1, OR of key.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high; all state updates only on posedge clock.
- Reset values: key=0, press=0, release=0, repeat=0, any_key=0, all counters 0, repeat FSMs IDLE.
  - Synchroniser flops reset to the released pin level so no spurious event follows reset.
- Polarity: each key_in bit is normalised (inverted when ACTIVE_LOW=1) before a 2-flop synchroniser. The output of the second flop is the "sample".
- Debounce, per key, independent:
  - If sample == key, the counter clears.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYC-1 and sample still differs, key takes sample, the counter clears, and press or release pulses for one cycle in the same cycle key changes.
  - Any single-cycle agreement with key during counting restarts the count (glitch rejection).
- Latency: from the pin edge, key changes after 2 (sync) + DEBOUNCE_CYC cycles.
- Repeat FSM, per key, states IDLE / DELAY / RPT, one shared counter:
  - IDLE -> DELAY on press; counter cleared.
  - DELAY: counter increments; at REPEAT_DELAY-1, pulse repeat, clear counter, go to RPT.
  - RPT: counter increments; at REPEAT_RATE-1, pulse repeat and clear counter.
  - Any state -> IDLE on release. A release in the same cycle as a would-be repeat pulse suppresses that pulse.
- press is never coincident with repeat; the first repeat comes exactly REPEAT_DELAY cycles after press.
- Simultaneous events on different keys are fully independent; multiple bits may pulse in the same cycle.
- Reset mid-operation: all state returns to reset values at once, and pending pulses are dropped.
  - A key held through reset is reported as a new press DEBOUNCE_CYC+2 cycles after reset deassert.
- Counters saturate and never wrap. The comparisons above bound them, so a counter never exceeds its parameter-1.
- All outputs are registered; there are no combinational paths from key_in to outputs.

Decomposition:
- Package key_pkg holds:
  - the repeat state enum (IDLE, DELAY, RPT);
  - the NKEYS=4 constant;
  - default cycle-count constants derived from 25 MHz.
- Sub-module key_channel holds one key's synchroniser, debounce counter and repeat FSM. The top instantiates it NKEYS times and forms any_key.

Test Plan (DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5, ACTIVE_LOW=1):
- Reset with key_in=4'b1111 held 10 cycles -> all outputs 0 throughout and after; no pulses.
- key_in[0] falls at cycle T and stays low -> key[0]=1 and press[0]=1 for exactly 1 cycle at T+6; any_key=1 from T+6.
- key_in[1] low for 3 cycles then high, repeated for 40 cycles -> key[1] stays 0; no press or release.
- key_in[2] held low 60 cycles after acceptance -> repeat[2] pulses at press+20, +25, +30 ... (9 pulses in 60 cycles); releasing gives release[2] 6 cycles after the pin rises and no further repeats.
- key_in[0] and key_in[3] fall in the same cycle -> press=4'b1001 in one cycle.
- Key held, reset asserted mid-repeat for 1 cycle -> outputs 0 next cycle; press reappears 6 cycles after reset deassert.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and default timing constants for the key conditioner
package key_pkg;

    localparam int NKEYS  = 4;
    localparam int CLK_HZ = 25_000_000;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at CLK_HZ
    localparam int DEF_DEBOUNCE_CYC = CLK_HZ / 100;
    localparam int DEF_REPEAT_DELAY = CLK_HZ / 2;
    localparam int DEF_REPEAT_RATE  = CLK_HZ / 10;
    localparam int DEF_CNT_W        = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: 2-flop synchroniser, debounce counter and auto-repeat FSM
module key_channel
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic key_pin,
    output logic key,
    output logic key_next,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             key_q, key_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rpt_q, rpt_d;
    rpt_state_e       state_q, state_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    always_comb begin
        sync1_d  = ACTIVE_LOW ? ~key_pin : key_pin;
        sync2_d  = sync1_q;
        key_d    = key_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        // Any cycle of agreement leaves db_cnt_d at zero, restarting the count
        if (sync2_q != key_q) begin
            if (db_cnt_q >= DB_LAST) begin
                key_d   = sync2_q;
                press_d = sync2_q;
                rel_d   = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_d     = 1'b0;
        case (state_q)
            IDLE: begin
                rpt_cnt_d = '0;
                if (press_d) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (rpt_cnt_q >= RD_LAST) begin
                    rpt_d     = 1'b1;
                    rpt_cnt_d = '0;
                    state_d   = RPT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            RPT: begin
                if (rpt_cnt_q >= RR_LAST) begin
                    rpt_d     = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end
        endcase
        // Release wins over a repeat tick landing in the same cycle
        if (rel_d) begin
            state_d   = IDLE;
            rpt_cnt_d = '0;
            rpt_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            key_q     <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            rpt_q     <= 1'b0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            key_q     <= key_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            rpt_q     <= rpt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign key      = key_q;
    assign key_next = key_d;
    assign press    = press_q;
    assign rel      = rel_q;
    assign rpt      = rpt_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced level and press/release/repeat pulses for the push-buttons
module key_conditioner
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_in,
    output logic [NKEYS-1:0] key,
    output logic [NKEYS-1:0] press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_repeat,
    output logic             any_key
);

    logic [NKEYS-1:0] key_next;
    logic             any_key_q, any_key_d;

    for (genvar g = 0; g < NKEYS; g++) begin : g_chan
        key_channel #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .key_pin  (key_in[g]),
            .key      (key[g]),
            .key_next (key_next[g]),
            .press    (press[g]),
            .rel      (key_release[g]),
            .rpt      (key_repeat[g])
        );
    end

    // Built from next-state keys so any_key stays in step with key
    always_comb begin
        any_key_d = |key_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            any_key_q <= 1'b0;
        end else begin
            any_key_q <= any_key_d;
        end
    end

    assign any_key = any_key_q;

endmodule
